// File: rtl/icache_pkg.sv
// Shared instruction-cache constants, refill FSM encoding and line address helpers.
package icache_pkg;

  localparam int ADDR_W      = 16;
  localparam int INSTR_W     = 16;
  localparam int WORDS       = 4;
  localparam int LINE_W      = WORDS * INSTR_W;
  localparam int OFFSET_BITS = 3;
  localparam int BEAT_W      = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } refill_state_e;

  // Base of the 8-byte line holding a byte address.
  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'((1 << OFFSET_BITS) - 1);
  endfunction

  // Beat offset only ever lands in the cleared offset bits, so the line never wraps.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [BEAT_W-1:0] beat);
    return base | ADDR_W'({beat, 1'b0});
  endfunction

endpackage

// File: rtl/icache_refill_unit.sv
// Instruction cache miss responder: fetches four 16-bit beats from backing memory
// and hands the assembled 64-bit line back to the cache.
module icache_refill_unit
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              line_valid,
  output logic [LINE_W-1:0] line_data,
  output logic [ADDR_W-1:0] line_addr
);

  refill_state_e     state;
  logic [ADDR_W-1:0] base;
  logic [BEAT_W-1:0] beat;

  // Strobes are entered together with the state that owns them so every output is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base       <= '0;
      beat       <= '0;
      req_ready  <= 1'b1;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      line_valid <= 1'b0;
      line_data  <= '0;
      line_addr  <= '0;
    end else begin
      mem_rd     <= 1'b0;
      line_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            base      <= line_base(req_addr);
            beat      <= '0;
            mem_addr  <= line_base(req_addr);
            mem_rd    <= 1'b1;
            req_ready <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (mem_valid) begin
            line_data[beat*INSTR_W +: INSTR_W] <= mem_rdata;
            if (beat == '0) begin
              line_addr <= base;
            end
            if (beat == BEAT_W'(WORDS - 1)) begin
              line_valid <= 1'b1;
              state      <= DONE;
            end else begin
              beat     <= beat + 1'b1;
              mem_addr <= beat_addr(base, beat + 1'b1);
              mem_rd   <= 1'b1;
              state    <= ISSUE;
            end
          end
        end
        DONE: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_unit.sv
// Randomized self-checking bench for icache_refill_unit against a transaction-level
// model of the refill protocol and a responding backing memory.
module tb_icache_refill_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_ready;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic        line_valid;
  logic [63:0] line_data;
  logic [15:0] line_addr;

  icache_refill_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .line_valid(line_valid), .line_data(line_data), .line_addr(line_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] memArr [0:32767];

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: one refill = four reads, each issued the cycle after the previous data lands.
  bit          active = 0;
  bit          waiting = 0;
  bit          respNow = 0;
  bit          lineDone = 0;
  bit          spurious = 0;
  logic [15:0] base = 0;
  logic [15:0] respData = 0;
  logic [63:0] expLine = 0;
  logic [15:0] expLineAddr = 0;
  logic [15:0] expMemAddr = 0;
  int          cyc = 0;
  int          issued = 0;
  int          delivered = 0;
  int          nextRdCycle = 0;
  int          respCycle = 0;
  int          lastRdCycle = 0;
  int          extraWaits = 0;
  int          fixedDelay = 1;

  int          dutLvCycle = 0;
  int          dutLvPulses = 0;
  int          dutRdPulses = 0;
  int          dutReadyBusy = 0;
  int          dutBusyRd = 0;
  logic [63:0] dutLineData = 0;
  logic [15:0] dutLineAddr = 0;
  logic [15:0] dutRdAddrs [$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
    else
      passCount++;
  endtask

  task automatic stepCycle();
    bit          acc;
    bit          expRd;
    bit          expLv;
    int          dly;
    logic [15:0] accAddr;
    acc     = req_valid && req_ready && !rst;
    accAddr = req_addr;
    @(negedge clk);
    if (!rst) begin
      if (active && respNow) begin
        expLine[delivered*16 +: 16] = respData;
        if (delivered == 0) expLineAddr = base;
        delivered++;
        nextRdCycle = cyc + 1;
      end
      if (!active && acc) begin
        active = 1; base = {accAddr[15:3], 3'b000};
        cyc = 0; issued = 0; delivered = 0; nextRdCycle = 1; extraWaits = 0;
        dutRdAddrs.delete(); dutRdPulses = 0; dutLvCycle = -1;
      end
    end
    respNow = 0;
    if (active) cyc++;

    if (mem_rd === 1'b1) begin
      dutRdPulses++;
      dutRdAddrs.push_back(mem_addr);
      if (mem_addr >= 16'h0010 && mem_addr <= 16'h0016) dutBusyRd++;
    end
    if (line_valid === 1'b1) begin
      dutLvPulses++; dutLvCycle = cyc; dutLineData = line_data; dutLineAddr = line_addr;
    end
    if (active && req_ready === 1'b1) dutReadyBusy++;

    checkOutput("req_ready", req_ready, !active);
    expRd = active && issued < 4 && cyc == nextRdCycle;
    checkOutput("mem_rd", mem_rd, expRd);
    if (expRd) begin
      expMemAddr = base + 16'(2 * issued);
      issued++;
      lastRdCycle = cyc;
      dly = (fixedDelay > 0) ? fixedDelay : int'($urandom_range(1, 4));
      respCycle = cyc + dly;
      extraWaits += dly - 1;
      waiting = 1;
    end
    checkOutput("mem_addr", mem_addr, expMemAddr);
    expLv = active && delivered == 4 && cyc == nextRdCycle;
    checkOutput("line_valid", line_valid, expLv);
    checkOutput("line_data", line_data, expLine);
    checkOutput("line_addr", line_addr, expLineAddr);
    if (expLv) begin
      checkOutput("latency", cyc, 9 + extraWaits);
      active = 0;
      lineDone = 1;
    end

    mem_valid = 0;
    mem_rdata = 16'($urandom);
    if (active && waiting && cyc == respCycle) begin
      mem_valid = 1;
      mem_rdata = memArr[expMemAddr[15:1]];
      respData  = mem_rdata;
      respNow   = 1;
      waiting   = 0;
    end else if (spurious && !waiting && ($urandom % 2 == 1)) begin
      mem_valid = 1;
    end else if (spurious && expRd && ($urandom % 2 == 1)) begin
      mem_valid = 1;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input int delayMode,
                               input bit useBusy, input logic [15:0] busyAddr);
    fixedDelay = delayMode;
    lineDone   = 0;
    req_valid  = 1; req_addr = addr;
    for (int i = 0; i < 300 && !lineDone; i++) begin
      stepCycle();
      if (active && useBusy) req_addr = busyAddr;
      if (lineDone) req_valid = 0;
    end
    checkOutput("refill_done", lineDone, 1);
    req_valid = 0;
    stepCycle();
    stepCycle();
  endtask

  task automatic checkRdAddrs(input string name, input logic [15:0] a0, input logic [15:0] step);
    checkOutput({name, "_rd_count"}, dutRdPulses, 4);
    for (int i = 0; i < 4; i++)
      checkOutput({name, "_rd_addr"}, (dutRdAddrs.size() > i) ? dutRdAddrs[i] : 16'hxxxx,
                  a0 + 16'(i) * step);
  endtask

  task automatic applyResetMidRefill();
    bit fired = 0;
    int lvBefore;
    fixedDelay = 3; spurious = 0; lineDone = 0;
    req_valid = 1; req_addr = 16'h0040;
    for (int i = 0; i < 100 && !fired; i++) begin
      stepCycle();
      if (active && issued == 3 && cyc == lastRdCycle + 1) begin
        rst = 1; mem_valid = 0; req_valid = 0; respNow = 0; waiting = 0;
        #1;
        checkOutput("rst_mid_mem_rd", mem_rd, 0);
        checkOutput("rst_mid_req_ready", req_ready, 1);
        checkOutput("rst_mid_line_data", line_data, 0);
        checkOutput("rst_mid_line_valid", line_valid, 0);
        active = 0; expLine = 0; expLineAddr = 0; expMemAddr = 0;
        fired = 1;
      end
    end
    checkOutput("rst_mid_reached", fired, 1);
    lvBefore = dutLvPulses;
    stepCycle();
    stepCycle();
    rst = 0;
    repeat (12) stepCycle();
    checkOutput("rst_mid_no_line_valid", dutLvPulses - lvBefore, 0);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) memArr[i] = 16'(i);
    rst = 1; req_valid = 0; req_addr = 0; mem_valid = 0; mem_rdata = 0;
    stepCycle();
    checkOutput("reset_req_ready", req_ready, 1);
    checkOutput("reset_line_data", line_data, 0);
    stepCycle();
    rst = 0;
    stepCycle();

    applyStimulus(16'h0000, 1, 0, 16'h0);
    checkOutput("basic_latency", dutLvCycle, 9);
    checkOutput("basic_data", dutLineData, 64'h0003000200010000);
    checkOutput("basic_addr", dutLineAddr, 16'h0000);
    checkRdAddrs("basic", 16'h0000, 16'h2);

    spurious = 1;
    applyStimulus(16'h000A, 1, 0, 16'h0);
    checkOutput("unaligned_data", dutLineData, 64'h0007000600050004);
    checkOutput("unaligned_addr", dutLineAddr, 16'h0008);
    checkRdAddrs("unaligned", 16'h0008, 16'h2);
    spurious = 0;

    applyStimulus(16'h0020, 3, 0, 16'h0);
    checkOutput("slow_latency", dutLvCycle, 17);
    checkOutput("slow_data", dutLineData, 64'h0013001200110010);
    checkRdAddrs("slow", 16'h0020, 16'h2);

    dutReadyBusy = 0; dutBusyRd = 0;
    applyStimulus(16'h0000, 2, 1, 16'h0010);
    checkOutput("busy_ready_low", dutReadyBusy, 0);
    checkOutput("busy_no_foreign_rd", dutBusyRd, 0);

    applyResetMidRefill();

    applyStimulus(16'hFFFE, 1, 0, 16'h0);
    checkOutput("top_addr", dutLineAddr, 16'hFFF8);
    checkOutput("top_data", dutLineData, 64'h7FFF7FFE7FFD7FFC);
    checkRdAddrs("top", 16'hFFF8, 16'h2);

    for (int i = 0; i < 32768; i++) memArr[i] = 16'($urandom);
    spurious = 1;
    for (int n = 0; n < 20; n++) begin
      applyStimulus(16'($urandom), 0, 0, 16'h0);
      repeat ($urandom_range(0, 3)) stepCycle();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
